uart_tx_arbiter: RTL and testbench

Shares one uart_tx instance between N byte producers using a round-robin scheme. Each requester presents a byte with a valid/ready handshake. The arbiter latches the byte, drives uart_tx's data/send inputs and waits for uart_tx's sent pulse. It then signals per-requester completion and arbitrates again. A watchdog aborts a transfer if uart_tx never reports completion.

---
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among N byte producers.
// Holds send until uart_tx reports the byte sent; an optional watchdog aborts stuck transfers.
module uart_tx_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   req_done,
    output logic [7:0]     tx_data,
    output logic           tx_send,
    input  logic           tx_sent,
    output logic           busy,
    output logic [2:0]     grant,
    output logic           timeout_err
);
    localparam logic [15:0]  WdogLast = 16'(TIMEOUT - 1);
    localparam logic [2:0]   LastReq  = 3'(N - 1);
    localparam logic [N-1:0] OneHot0  = {{(N - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e      state_q;
    logic [15:0] wdog_q;

    logic [7:0]  valid_ext;
    logic [63:0] data_ext;
    logic [2:0]  cand;
    logic [2:0]  pick;
    logic        pick_found;

    // Search starts one past the last grant so the most recently served requester goes last.
    always_comb begin
        valid_ext  = 8'(req_valid);
        data_ext   = 64'(req_data);
        cand       = grant;
        pick       = grant;
        pick_found = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            cand = 3'((int'(grant) + k) % int'(N));
            if (!pick_found && valid_ext[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wdog_q      <= '0;
            req_ready   <= '0;
            req_done    <= '0;
            tx_data     <= '0;
            tx_send     <= 1'b0;
            busy        <= 1'b0;
            grant       <= LastReq;
            timeout_err <= 1'b0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        tx_data   <= data_ext[{pick, 3'b000} +: 8];
                        tx_send   <= 1'b1;
                        req_ready <= OneHot0 << pick;
                        grant     <= pick;
                        wdog_q    <= '0;
                        busy      <= 1'b1;
                        state_q   <= StSend;
                    end
                end
                StSend: begin
                    wdog_q <= wdog_q + 16'd1;
                    // A completion arriving on the watchdog's last cycle still counts as sent.
                    if (tx_sent) begin
                        tx_send  <= 1'b0;
                        req_done <= OneHot0 << grant;
                        state_q  <= StGap;
                    end else if ((TIMEOUT != 0) && (wdog_q == WdogLast)) begin
                        tx_send     <= 1'b0;
                        timeout_err <= 1'b1;
                        state_q     <= StGap;
                    end
                end
                StGap: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: transaction-level round-robin model plus a uart_tx stand-in.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_done;
    logic [7:0]     tx_data;
    logic           tx_send;
    logic           tx_sent;
    logic           busy;
    logic [2:0]     grant;
    logic           timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_sent     (tx_sent),
        .busy        (busy),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: one transfer at a time, described by its start and end cycles.
    bit             in_send;
    bit             end_done;
    bit             err_flag;
    int             start_cyc;
    int             end_cyc;
    int             idle_from;
    int             last_grant;
    int             force_d;
    int             guard;
    logic [7:0]     cur_byte;
    logic [N-1:0]   prev_valid;
    logic [8*N-1:0] prev_data;
    int             p_raise, p_drop, p_spur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        cyc++;
        rst     = 1'b1;
        tx_sent = 1'b0;
        @(negedge clk);
        cyc++;
        check("rst_ready", req_ready, 0);
        check("rst_done", req_done, 0);
        check("rst_txdata", tx_data, 0);
        check("rst_send", tx_send, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, N - 1);
        check("rst_terr", timeout_err, 0);
        rst        = 1'b0;
        in_send    = 1'b0;
        err_flag   = 1'b0;
        last_grant = N - 1;
        idle_from  = cyc;
        prev_valid = req_valid;
        prev_data  = req_data;
    endtask

    task automatic step();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_done;
        int g, d;
        @(negedge clk);
        cyc++;
        exp_ready = '0;
        exp_done  = '0;
        if (in_send && cyc == end_cyc) begin
            in_send   = 1'b0;
            idle_from = cyc + 1;
            if (end_done) exp_done = 4'(1 << last_grant);
            else err_flag = 1'b1;
        end else if (!in_send && cyc - 1 >= idle_from && prev_valid != '0) begin
            g          = rr_pick(prev_valid, last_grant);
            exp_ready  = 4'(1 << g);
            last_grant = g;
            cur_byte   = prev_data[8*g +: 8];
            in_send    = 1'b1;
            start_cyc  = cyc;
            if (force_d > 0) d = force_d;
            else begin
                case ($urandom_range(9))
                    0:       d = TO;
                    1:       d = TO + 5;
                    default: d = $urandom_range(15, 1);
                endcase
            end
            end_done = (d <= TO);
            end_cyc  = end_done ? cyc + d : cyc + TO;
        end
        check("ready", req_ready, exp_ready);
        check("done", req_done, exp_done);
        check("send", tx_send, in_send);
        check("busy", busy, in_send || cyc < idle_from);
        check("grant", grant, last_grant);
        check("terr", timeout_err, err_flag);
        if (in_send) check("txdata", tx_data, cur_byte);

        // uart_tx stand-in: real completion pulse, or spurious pulses outside SEND.
        tx_sent = 1'b0;
        if (in_send && end_done && cyc == end_cyc - 1) tx_sent = 1'b1;
        else if (!in_send && $urandom_range(99) < p_spur) tx_sent = 1'b1;

        for (int i = 0; i < N; i++) begin
            if (exp_ready[i] || !req_valid[i]) begin
                if ($urandom_range(99) < p_raise) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end else if ($urandom_range(99) < p_drop) begin
                req_valid[i] = 1'b0;
            end
        end
        prev_valid = req_valid;
        prev_data  = req_data;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_sent   = 1'b0;
        p_raise   = 0;
        p_drop    = 0;
        p_spur    = 0;
        force_d   = 0;
        apply_reset();

        // Single request, completion 10 cycles after send rises.
        req_valid      = 4'b0001;
        req_data[7:0]  = 8'h41;
        prev_valid     = req_valid;
        prev_data      = req_data;
        force_d        = 10;
        repeat (20) step();

        // Everyone pending continuously: strict rotation, spurious sent pulses outside SEND.
        force_d = 0;
        p_raise = 100;
        p_spur  = 20;
        repeat (300) step();

        // Mixed traffic with drops before grant.
        p_raise = 30;
        p_drop  = 5;
        repeat (1500) step();

        // Sparse traffic, mostly idle, frequent spurious pulses.
        p_raise = 5;
        p_drop  = 0;
        p_spur  = 30;
        repeat (500) step();

        // Reset five cycles into a transfer that would otherwise time out.
        p_raise = 100;
        p_spur  = 0;
        force_d = TO + 10;
        guard   = 0;
        while (!(in_send && cyc == start_cyc + 5) && guard < 200) begin
            step();
            guard++;
        end
        check("midsend_send", tx_send, 1);
        apply_reset();
        force_d = 0;
        p_raise = 40;
        p_spur  = 10;
        repeat (300) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
